mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Memory stage directly downstream of the ALU. It takes the ALU result as a byte address, or as a pass-through writeback value, and performs aligned byte/half/word loads and stores against a single-port data memory with a req/ack handshake. It flags exceptions for ALU overflow, misalignment and memory timeout, then presents writeback data to the next stage through a valid/ready handshake.

Parameters:
TIMEOUT, 16, max cycles waiting for memAck before a timeout exception (range 2..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
inValid  in  1  upstream op valid
inReady  out  1  unit can accept an op this cycle
aluResult  in  32  ALU result: address for load/store, else writeback value
storeData  in  32  store data, from register operand 2
aluOverflow  in  1  ALU overflow flag for this op
memRead  in  1  op is a load
memWrite  in  1  op is a store (memRead=memWrite=1 is treated as a load)
size  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as word)
signExt  in  1  sign-extend load data
rdIn  in  5  destination register tag
memReq  out  1  memory request
memWe  out  1  1=write
memAddr  out  32  word-aligned address ({aluResult[31:2],2'b00})
memWData  out  32  lane-replicated store data
memBe  out  4  byte enables
memAck  in  1  memory done; memRData valid on the same cycle for reads
memRData  in  32  read data
outValid  out  1  result valid to downstream
outReady  in  1  downstream accepts
wbData  out  32  writeback value
rdOut  out  5  destination tag
excValid  out  1  exception on this result (qualified by outValid)
excCode  out  2  00 overflow, 01 misaligned, 10 timeout

Behaviour:
- Reset (async, rst_n low): state=IDLE. inReady=1; outValid, memReq, memWe, excValid = 0. memAddr, memWData, memBe, wbData, excCode = 0. rdOut=0. Timeout counter=0.
- Assertion mid-transfer aborts immediately; memReq drops asynchronously; no result is produced.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: inReady=1. Capture on inValid, then evaluate in priority order:
  - aluOverflow=1 -> RESP, excValid=1, excCode=00, no memory access. Overflow exceptions apply to every op type, memory or not.
  - load/store misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> RESP, excCode=01, no memory access.
  - load/store -> REQ.
  - otherwise -> RESP with wbData=aluResult.
- REQ: memReq=1, memWe=memWrite&~memRead.
  - Byte lanes are little-endian. Byte: memBe=1<<addr[1:0], memWData={4{storeData[7:0]}}. Half: memBe=addr[1]?1100:0011, memWData={2{storeData[15:0]}}. Word: memBe=1111.
  - Loads drive memBe the same way.
  - memAck in this cycle -> RESP. Otherwise -> WAIT, counter=1.
- WAIT: memReq held, all memory outputs stable.
  - memAck -> RESP.
  - counter reaches TIMEOUT without ack -> memReq=0, RESP, excCode=10, wbData=0.
  - Otherwise counter increments.
- Load data is captured on the memAck cycle: select the lane by addr, then zero- or sign-extend per signExt. Stores produce wbData=0.
- RESP: outValid=1. wbData, rdOut, excValid and excCode are stable until outReady.
  - When outValid&outReady: go to IDLE; the next op can be accepted on the following cycle (inReady low while in RESP).
- inReady=0 in REQ, WAIT and RESP. Single-entry buffering only; no pipelining.
- Latency:
  - Non-memory or exception op: 1 cycle to outValid.
  - Memory op with ack on the first REQ cycle: 2 cycles to outValid.
  - Each additional WAIT cycle adds 1.
- memAck outside REQ/WAIT is ignored.
- The counter resets to 0 on every entry to IDLE.

Test Plan:
- Pass-through: aluResult=0x0000_1234, no mem op, outReady=1 -> outValid one cycle later, wbData=0x1234, rdOut=rdIn, excValid=0, memReq never asserted.
- Byte load with sign extension: addr=0x103, size=00, signExt=1, memRData=0x80FF_0000, ack on the first REQ cycle -> memAddr=0x100, memBe=1000, wbData=0xFFFF_FF80. With signExt=0 -> wbData=0x0000_0080.
- Half store: addr=0x202, storeData=0xDEAD_BEEF -> memWe=1, memBe=1100, memWData=0xBEEF_BEEF, wbData=0.
- Misalign and overflow: word load at addr=0x0000_0006 -> excCode=01, no memReq. aluOverflow=1 together with a misaligned address -> excCode=00.
- Timeout, backpressure and reset: memAck never asserted with TIMEOUT=16 -> memReq drops after 16 WAIT-accumulated cycles, excCode=10. Hold outReady=0 for 5 cycles -> outputs stable and inReady=0. rst_n low during WAIT -> memReq=0 immediately and state IDLE after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage behind the ALU. Accepts one op at a time,
// performs aligned byte/half/word loads and stores over a req/ack memory
// port, flags overflow/misalignment/timeout exceptions and hands the
// writeback value downstream over a valid/ready handshake.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inValid_i,
  output logic        inReady_o,
  input  logic [31:0] aluResult_i,
  input  logic [31:0] storeData_i,
  input  logic        aluOverflow_i,
  input  logic        memRead_i,
  input  logic        memWrite_i,
  input  logic [1:0]  size_i,
  input  logic        signExt_i,
  input  logic [4:0]  rdIn_i,
  output logic        memReq_o,
  output logic        memWe_o,
  output logic [31:0] memAddr_o,
  output logic [31:0] memWData_o,
  output logic [3:0]  memBe_o,
  input  logic        memAck_i,
  input  logic [31:0] memRData_i,
  output logic        outValid_o,
  input  logic        outReady_i,
  output logic [31:0] wbData_o,
  output logic [4:0]  rdOut_o,
  output logic        excValid_o,
  output logic [1:0]  excCode_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  localparam logic [7:0] TimeoutCnt = TIMEOUT[7:0];
  localparam logic [1:0] ExcOverflow = 2'b00;
  localparam logic [1:0] ExcMisalign = 2'b01;
  localparam logic [1:0] ExcTimeout  = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [1:0]  size_q, size_d;
  logic        signExt_q, signExt_d;
  logic        isLoad_q, isLoad_d;
  logic        we_q, we_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wb_q, wb_d;
  logic        exc_q, exc_d;
  logic [1:0]  code_q, code_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        isMem;
  logic        misaligned;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadData;

  // Classify the incoming op: does it touch memory, and is it misaligned
  always_comb begin
    isMem      = memRead_i | memWrite_i;
    misaligned = 1'b0;
    if (size_i == 2'b01) begin
      misaligned = aluResult_i[0];
    end else if (size_i[1]) begin
      misaligned = |aluResult_i[1:0];
    end
  end

  // Select the addressed little-endian lane of the read data and extend it
  always_comb begin
    case (addr_q[1:0])
      2'd0:    loadByte = memRData_i[7:0];
      2'd1:    loadByte = memRData_i[15:8];
      2'd2:    loadByte = memRData_i[23:16];
      default: loadByte = memRData_i[31:24];
    endcase
    loadHalf = addr_q[1] ? memRData_i[31:16] : memRData_i[15:0];
    if (size_q == 2'b00) begin
      loadData = {{24{signExt_q & loadByte[7]}}, loadByte};
    end else if (size_q == 2'b01) begin
      loadData = {{16{signExt_q & loadHalf[15]}}, loadHalf};
    end else begin
      loadData = memRData_i;
    end
  end

  // Next-state logic: capture in IDLE, wait for ack or timeout, hold result until taken
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    size_d    = size_q;
    signExt_d = signExt_q;
    isLoad_d  = isLoad_q;
    we_d      = we_q;
    rd_d      = rd_q;
    wb_d      = wb_q;
    exc_d     = exc_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (inValid_i) begin
          addr_d    = aluResult_i;
          sdata_d   = storeData_i;
          size_d    = size_i;
          signExt_d = signExt_i;
          isLoad_d  = memRead_i;
          we_d      = memWrite_i & ~memRead_i;
          rd_d      = rdIn_i;
          wb_d      = 32'd0;
          exc_d     = 1'b0;
          code_d    = 2'b00;
          if (aluOverflow_i) begin
            exc_d   = 1'b1;
            code_d  = ExcOverflow;
            state_d = RESP;
          end else if (isMem && misaligned) begin
            exc_d   = 1'b1;
            code_d  = ExcMisalign;
            state_d = RESP;
          end else if (isMem) begin
            state_d = REQ;
          end else begin
            wb_d    = aluResult_i;
            state_d = RESP;
          end
        end
      end
      REQ: begin
        if (memAck_i) begin
          wb_d    = isLoad_q ? loadData : 32'd0;
          state_d = RESP;
        end else begin
          cnt_d   = 8'd1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (memAck_i) begin
          wb_d    = isLoad_q ? loadData : 32'd0;
          state_d = RESP;
        end else if (cnt_q >= TimeoutCnt) begin
          wb_d    = 32'd0;
          exc_d   = 1'b1;
          code_d  = ExcTimeout;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        if (outReady_i) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and captured-operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      sdata_q   <= 32'd0;
      size_q    <= 2'b00;
      signExt_q <= 1'b0;
      isLoad_q  <= 1'b0;
      we_q      <= 1'b0;
      rd_q      <= 5'd0;
      wb_q      <= 32'd0;
      exc_q     <= 1'b0;
      code_q    <= 2'b00;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      size_q    <= size_d;
      signExt_q <= signExt_d;
      isLoad_q  <= isLoad_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      wb_q      <= wb_d;
      exc_q     <= exc_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
    end
  end

  // Memory port: driven from registers only while a request is outstanding, zero otherwise
  always_comb begin
    memReq_o   = (state_q == REQ) || (state_q == WAIT);
    memWe_o    = 1'b0;
    memAddr_o  = 32'd0;
    memWData_o = 32'd0;
    memBe_o    = 4'b0000;
    if (memReq_o) begin
      memWe_o   = we_q;
      memAddr_o = {addr_q[31:2], 2'b00};
      if (size_q == 2'b00) begin
        memBe_o    = 4'b0001 << addr_q[1:0];
        memWData_o = {4{sdata_q[7:0]}};
      end else if (size_q == 2'b01) begin
        memBe_o    = addr_q[1] ? 4'b1100 : 4'b0011;
        memWData_o = {2{sdata_q[15:0]}};
      end else begin
        memBe_o    = 4'b1111;
        memWData_o = sdata_q;
      end
    end
  end

  assign inReady_o  = (state_q == IDLE);
  assign outValid_o = (state_q == RESP);
  assign wbData_o   = wb_q;
  assign rdOut_o    = rd_q;
  assign excValid_o = exc_q;
  assign excCode_o  = code_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed cases with literal expectations,
// then randomized ops checked every cycle against a transaction-level model.
module tb_mem_access_unit;

  localparam int TO = 16;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] aluResult = '0;
  logic [31:0] storeData = '0;
  logic        aluOverflow = 1'b0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        signExt = 1'b0;
  logic [4:0]  rdIn = '0;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [3:0]  memBe;
  logic        memAck = 1'b0;
  logic [31:0] memRData = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [31:0] wbData;
  logic [4:0]  rdOut;
  logic        excValid;
  logic [1:0]  excCode;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .inValid_i(inValid), .inReady_o(inReady),
    .aluResult_i(aluResult), .storeData_i(storeData), .aluOverflow_i(aluOverflow),
    .memRead_i(memRead), .memWrite_i(memWrite), .size_i(size), .signExt_i(signExt),
    .rdIn_i(rdIn),
    .memReq_o(memReq), .memWe_o(memWe), .memAddr_o(memAddr), .memWData_o(memWData),
    .memBe_o(memBe), .memAck_i(memAck), .memRData_i(memRData),
    .outValid_o(outValid), .outReady_i(outReady), .wbData_o(wbData), .rdOut_o(rdOut),
    .excValid_o(excValid), .excCode_o(excCode)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model of the op in flight, expressed as cycle numbers and expected values
  bit          busy = 1'b0;
  int          cyc = 0;
  int          tAcc, tResp, ackCyc;
  bit          mAccess, mLoad, mStore, mExc;
  logic [1:0]  mCode, mSize, mOff;
  logic [31:0] mWb, mAddr, mWData;
  logic [3:0]  mBe;
  logic [4:0]  mRd;
  bit          mSx;
  int          planDelay = 0;

  // Environment knobs and what the DUT showed for the last op
  bit          holdReady = 1'b0;
  bit          useFixedRData = 1'b0;
  logic [31:0] fixedRData = '0;
  logic [31:0] lastWb, lastReqAddr, lastReqWData;
  logic [4:0]  lastRd;
  logic        lastExc, lastReqWe;
  logic [1:0]  lastCode;
  logic [3:0]  lastReqBe;
  int          reqCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] expLoad(input logic [31:0] d, input logic [1:0] off,
                                          input logic [1:0] sz, input bit sx);
    int nbits;
    int shift;
    longint unsigned v;
    longint unsigned mask;
    if (sz == 2'd0) begin
      nbits = 8;  shift = 8 * int'(off);
    end else if (sz == 2'd1) begin
      nbits = 16; shift = (off >= 2'd2) ? 16 : 0;
    end else begin
      nbits = 32; shift = 0;
    end
    mask = (64'd1 << nbits) - 64'd1;
    v = ({32'd0, d} >> shift) & mask;
    if (sx && (((v >> (nbits - 1)) & 64'd1) == 64'd1)) v = v | ~mask;
    return v[31:0];
  endfunction

  // Per-cycle compare process; also advances the model
  initial begin
    bit inWin;
    bit mis;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        busy = 1'b0;
        checkOutput("rst inReady", 32'(inReady), 32'd1);
        checkOutput("rst outValid", 32'(outValid), 32'd0);
        checkOutput("rst memReq", 32'(memReq), 32'd0);
        checkOutput("rst memWe", 32'(memWe), 32'd0);
        checkOutput("rst memAddr", memAddr, 32'd0);
        checkOutput("rst memWData", memWData, 32'd0);
        checkOutput("rst memBe", 32'(memBe), 32'd0);
        checkOutput("rst wbData", wbData, 32'd0);
        checkOutput("rst rdOut", 32'(rdOut), 32'd0);
        checkOutput("rst excValid", 32'(excValid), 32'd0);
        checkOutput("rst excCode", 32'(excCode), 32'd0);
      end else if (!busy) begin
        checkOutput("idle inReady", 32'(inReady), 32'd1);
        checkOutput("idle outValid", 32'(outValid), 32'd0);
        checkOutput("idle memReq", 32'(memReq), 32'd0);
        if (inValid) begin
          mLoad   = memRead;
          mStore  = memWrite && !memRead;
          mSize   = size;
          mOff    = aluResult[1:0];
          mSx     = signExt;
          mRd     = rdIn;
          mAddr   = aluResult & 32'hFFFF_FFFC;
          mBe     = (size == 2'd0) ? 4'(1 << mOff) : (size == 2'd1) ? ((mOff >= 2'd2) ? 4'hC : 4'h3) : 4'hF;
          mWData  = (size == 2'd0) ? 32'(storeData[7:0]) * 32'h0101_0101 :
                    (size == 2'd1) ? 32'(storeData[15:0]) * 32'h0001_0001 : storeData;
          mis     = (size == 2'd1 && mOff[0]) || (size >= 2'd2 && mOff != 2'd0);
          mWb     = 32'd0;
          mExc    = 1'b0;
          mCode   = 2'd0;
          mAccess = 1'b0;
          ackCyc  = -100;
          tAcc    = cyc;
          reqCount = 0;
          if (aluOverflow) begin
            mExc = 1'b1; mCode = 2'd0; tResp = cyc + 1;
          end else if ((mLoad || mStore) && mis) begin
            mExc = 1'b1; mCode = 2'd1; tResp = cyc + 1;
          end else if (!(mLoad || mStore)) begin
            mWb = aluResult; tResp = cyc + 1;
          end else if (planDelay <= TO) begin
            mAccess = 1'b1; ackCyc = cyc + 1 + planDelay; tResp = ackCyc + 1;
          end else begin
            mAccess = 1'b1; tResp = cyc + 2 + TO; mExc = 1'b1; mCode = 2'd2;
          end
          busy = 1'b1;
        end
      end else begin
        checkOutput("busy inReady", 32'(inReady), 32'd0);
        inWin = mAccess && cyc > tAcc && cyc < tResp;
        checkOutput("memReq", 32'(memReq), 32'(inWin));
        if (memReq) begin
          reqCount++;
          lastReqAddr = memAddr; lastReqBe = memBe; lastReqWData = memWData; lastReqWe = memWe;
        end
        if (inWin) begin
          checkOutput("memAddr", memAddr, mAddr);
          checkOutput("memBe", 32'(memBe), 32'(mBe));
          checkOutput("memWe", 32'(memWe), 32'(mStore));
          if (mStore) checkOutput("memWData", memWData, mWData);
          if (cyc == ackCyc && mLoad) mWb = expLoad(memRData, mOff, mSize, mSx);
        end
        if (cyc >= tResp) begin
          checkOutput("outValid", 32'(outValid), 32'd1);
          checkOutput("rdOut", 32'(rdOut), 32'(mRd));
          checkOutput("excValid", 32'(excValid), 32'(mExc));
          if (mExc) checkOutput("excCode", 32'(excCode), 32'(mCode));
          if (!mExc || mCode == 2'd2) checkOutput("wbData", wbData, mWb);
          if (outReady) begin
            lastWb = wbData; lastRd = rdOut; lastExc = excValid; lastCode = excCode;
            busy = 1'b0;
          end
        end else begin
          checkOutput("early outValid", 32'(outValid), 32'd0);
        end
      end
    end
  end

  // Memory responder and downstream ready; spurious acks only outside a request window
  initial begin
    forever begin
      @(posedge clk);
      #1;
      outReady = holdReady ? 1'b0 : ($urandom_range(0, 9) < 7);
      memRData = useFixedRData ? fixedRData : $urandom;
      if (busy && mAccess && (cyc + 1) == ackCyc) memAck = 1'b1;
      else if (busy && mAccess && (cyc + 1) > tAcc && (cyc + 1) < tResp) memAck = 1'b0;
      else memAck = ($urandom_range(0, 3) == 0);
    end
  end

  task automatic waitIdle();
    int guard = 0;
    while (busy && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    if (busy) begin
      total++; bad++;
      $display("[TB] FAIL drain: op still busy after %0d cycles, required 0", guard);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] sd, input bit ovf,
                               input bit rd, input bit wr, input logic [1:0] sz, input bit sx,
                               input logic [4:0] tag, input int delay, input bit waitDone);
    @(posedge clk);
    waitIdle();
    #1;
    aluResult = alu; storeData = sd; aluOverflow = ovf; memRead = rd; memWrite = wr;
    size = sz; signExt = sx; rdIn = tag; planDelay = delay; inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    aluResult = $urandom; storeData = $urandom; aluOverflow = 1'(($urandom_range(0, 1)));
    memRead = 1'($urandom_range(0, 1)); memWrite = 1'($urandom_range(0, 1));
    size = 2'($urandom_range(0, 3)); rdIn = 5'($urandom_range(0, 31));
    if (waitDone) waitIdle();
  endtask

  // Directed cases first, then randomized ops
  initial begin
    int r;
    int d;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus(32'h0000_1234, 32'h0, 0, 0, 0, 2'd2, 0, 5'd7, 0, 1);
    checkOutput("pass wbData", lastWb, 32'h0000_1234);
    checkOutput("pass rdOut", 32'(lastRd), 32'd7);
    checkOutput("pass excValid", 32'(lastExc), 32'd0);
    checkOutput("pass no memReq", 32'(reqCount), 32'd0);

    useFixedRData = 1'b1; fixedRData = 32'h80FF_0000;
    applyStimulus(32'h0000_0103, 32'h0, 0, 1, 0, 2'd0, 1, 5'd3, 0, 1);
    checkOutput("lb addr", lastReqAddr, 32'h0000_0100);
    checkOutput("lb be", 32'(lastReqBe), 32'h8);
    checkOutput("lb sext wb", lastWb, 32'hFFFF_FF80);
    applyStimulus(32'h0000_0103, 32'h0, 0, 1, 0, 2'd0, 0, 5'd3, 0, 1);
    checkOutput("lbu wb", lastWb, 32'h0000_0080);
    useFixedRData = 1'b0;

    applyStimulus(32'h0000_0202, 32'hDEAD_BEEF, 0, 0, 1, 2'd1, 0, 5'd9, 1, 1);
    checkOutput("sh we", 32'(lastReqWe), 32'd1);
    checkOutput("sh be", 32'(lastReqBe), 32'hC);
    checkOutput("sh wdata", lastReqWData, 32'hBEEF_BEEF);
    checkOutput("sh wb", lastWb, 32'd0);

    applyStimulus(32'h0000_0006, 32'h0, 0, 1, 0, 2'd2, 0, 5'd1, 0, 1);
    checkOutput("misalign code", 32'(lastCode), 32'd1);
    checkOutput("misalign no memReq", 32'(reqCount), 32'd0);
    applyStimulus(32'h0000_0006, 32'h0, 1, 1, 0, 2'd2, 0, 5'd1, 0, 1);
    checkOutput("ovf code", 32'(lastCode), 32'd0);
    checkOutput("ovf exc", 32'(lastExc), 32'd1);

    applyStimulus(32'h0000_0040, 32'h0, 0, 1, 0, 2'd2, 0, 5'd4, NEVER, 1);
    checkOutput("timeout code", 32'(lastCode), 32'd2);
    checkOutput("timeout req cycles", 32'(reqCount), 32'(1 + TO));
    checkOutput("timeout wb", lastWb, 32'd0);

    holdReady = 1'b1;
    applyStimulus(32'h0000_5555, 32'h0, 0, 0, 0, 2'd0, 0, 5'd12, 0, 0);
    repeat (5) @(posedge clk);
    #2;
    checkOutput("bp inReady", 32'(inReady), 32'd0);
    checkOutput("bp wbData", wbData, 32'h0000_5555);
    holdReady = 1'b0;
    waitIdle();

    applyStimulus(32'h0000_0080, 32'h0, 0, 1, 0, 2'd2, 0, 5'd5, NEVER, 0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 checkOutput("async memReq drop", 32'(memReq), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #2 checkOutput("post-reset inReady", 32'(inReady), 32'd1);
    applyStimulus(32'h0000_00AB, 32'h0, 0, 0, 0, 2'd0, 0, 5'd2, 0, 1);
    checkOutput("post-reset wb", lastWb, 32'h0000_00AB);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      d = (r < 7) ? $urandom_range(0, 3) : (r < 9) ? $urandom_range(4, TO) : NEVER;
      applyStimulus({24'(($urandom_range(0, 255))), 8'($urandom_range(0, 255))}, $urandom,
                    ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    d, 1);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
